// File: rtl/ramio_pkg.sv
// rtl/ramio_pkg.sv - shared types and constants for the ramio memory access adapter
//
// Purpose: access-size and FSM state enums, word size, straddle helper.
// Ports: none (package).
package ramio_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // True when an access of this size at this byte offset crosses into the next word.
  function automatic logic straddles(input size_e size, input logic [1:0] offset);
    return ((size == SZ_HALF) && (offset == 2'd3)) ||
           ((size == SZ_WORD) && (offset != 2'd0));
  endfunction

endpackage

// File: rtl/ramio_lane.sv
// rtl/ramio_lane.sv - byte-lane steering for stores and load extraction/extension
//
// Purpose: combinational lane logic shared by the aligned and split paths.
// Ports:
//   size        access size (none/byte/half/word)
//   offset      byte offset within the word
//   sign        sign-extend loads when set
//   store_word  right-justified store data
//   hi_word     upper word of the {hi, lo} load pair
//   lo_word     lower word of the {hi, lo} load pair
//   mask        8-bit byte mask across the two-word window
//   store_data  store data shifted into its lanes across the two-word window
//   load_data   extracted and extended load result
module ramio_lane
  import ramio_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        sign,
  input  logic [31:0] store_word,
  input  logic [31:0] hi_word,
  input  logic [31:0] lo_word,
  output logic [7:0]  mask,
  output logic [63:0] store_data,
  output logic [31:0] load_data
);

  logic [3:0]  base;
  logic [63:0] merged;

  always_comb begin
    base = 4'b0000;
    case (size)
      SZ_BYTE: base = 4'b0001;
      SZ_HALF: base = 4'b0011;
      SZ_WORD: base = 4'b1111;
      default: base = 4'b0000;
    endcase
    mask       = {4'b0000, base} << offset;
    store_data = {32'd0, store_word} << {offset, 3'b000};
    merged     = {hi_word, lo_word} >> {offset, 3'b000};
    load_data  = 32'd0;
    case (size)
      SZ_BYTE: load_data = {{24{sign & merged[7]}}, merged[7:0]};
      SZ_HALF: load_data = {{16{sign & merged[15]}}, merged[15:0]};
      SZ_WORD: load_data = merged[31:0];
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/ramio.sv
// rtl/ramio.sv - CPU load/store adapter in front of the SDRAM cache
//
// Purpose: turns byte/half/word accesses at any byte address into word-aligned
// cache accesses with a byte mask; aligned accesses pass straight through,
// word-straddling accesses are split into lo/hi accesses when
// RAMIO_SPLIT_ACCESS_EN is defined, otherwise flagged as misaligned.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   enable, address             CPU request valid and byte address
//   write_type, read_type       access sizes; read_type[2] selects sign extension
//   data_in                     right-justified store data
//   data_out, data_out_ready    extended load result and its valid
//   busy, misaligned            CPU hold request, straddle-not-performed flag
//   cache_enable, cache_address, cache_write_enable, cache_data_in   to cache
//   cache_data_out, cache_data_out_ready, cache_busy                 from cache
module ramio
  import ramio_pkg::*;
#(
  parameter int SettleCycles = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] address,
  input  logic [1:0]  write_type,
  input  logic [2:0]  read_type,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_ready,
  output logic        busy,
  output logic        misaligned,
  output logic        cache_enable,
  output logic [31:0] cache_address,
  output logic [3:0]  cache_write_enable,
  output logic [31:0] cache_data_in,
  input  logic [31:0] cache_data_out,
  input  logic        cache_data_out_ready,
  input  logic        cache_busy
);

`ifdef RAMIO_SPLIT_ACCESS_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam logic [1:0] SETTLE = 2'(SettleCycles);

  state_e      state;
  logic [1:0]  cnt;
  logic [31:0] lo_reg;
  logic [31:0] hi_reg;

  logic        writing, reading, req, straddle, phase_ready;
  size_e       size;
  logic [31:0] word_addr;
  logic [7:0]  mask;
  logic [63:0] store_data;
  logic [31:0] load_data;

  assign writing     = (write_type != 2'b00);
  // A write wins over a simultaneous read.
  assign reading     = !writing && (read_type[1:0] != 2'b00);
  assign req         = enable && (writing || reading);
  assign size        = writing ? size_e'(write_type) : size_e'(read_type[1:0]);
  assign straddle    = straddles(size, address[1:0]);
  assign word_addr   = {address[31:2], 2'b00};
  assign phase_ready = (cnt == 2'd0) && !cache_busy;

  // In Done the load comes from the two captured words; otherwise straight from the cache.
  ramio_lane u_lane (
    .size       (size),
    .offset     (address[1:0]),
    .sign       (read_type[2]),
    .store_word (data_in),
    .hi_word    ((state == ST_DONE) ? hi_reg : 32'd0),
    .lo_word    ((state == ST_DONE) ? lo_reg : cache_data_out),
    .mask       (mask),
    .store_data (store_data),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= 2'd0;
      lo_reg <= 32'd0;
      hi_reg <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (SPLIT_EN && req && straddle) begin
            cnt   <= SETTLE;
            state <= ST_LO;
          end
        end
        ST_LO: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else if (!cache_busy) begin
            if (reading) lo_reg <= cache_data_out;
            cnt   <= SETTLE;
            state <= ST_HI;
          end
        end
        ST_HI: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else if (!cache_busy) begin
            if (reading) hi_reg <= cache_data_out;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs stay combinational so aligned accesses add no latency and reset
  // clears them immediately.
  always_comb begin
    data_out           = 32'd0;
    data_out_ready     = 1'b0;
    busy               = 1'b0;
    misaligned         = 1'b0;
    cache_enable       = 1'b0;
    cache_address      = 32'd0;
    cache_write_enable = 4'b0000;
    cache_data_in      = 32'd0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (req && straddle) begin
            busy       = SPLIT_EN;
            misaligned = !SPLIT_EN;
          end else if (req) begin
            cache_enable       = 1'b1;
            cache_address      = word_addr;
            cache_write_enable = writing ? mask[3:0] : 4'b0000;
            cache_data_in      = store_data[31:0];
            busy               = cache_busy;
            data_out_ready     = reading && cache_data_out_ready;
            data_out           = reading ? load_data : 32'd0;
          end
        end
        ST_LO: begin
          busy               = 1'b1;
          cache_enable       = enable;
          cache_address      = word_addr;
          cache_data_in      = store_data[31:0];
          cache_write_enable = (enable && writing && phase_ready) ? mask[3:0] : 4'b0000;
        end
        ST_HI: begin
          busy               = 1'b1;
          cache_enable       = enable;
          cache_address      = word_addr + 32'd4;
          cache_data_in      = store_data[63:32];
          cache_write_enable = (enable && writing && phase_ready) ? mask[7:4] : 4'b0000;
        end
        default: begin
          data_out_ready = reading;
          data_out       = reading ? load_data : 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramio.sv
// tb/tb_ramio.sv - directed self-checking bench for ramio with a small cache model
module tb_ramio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] address = 32'd0;
  logic [1:0]  write_type = 2'b00;
  logic [2:0]  read_type = 3'b000;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        data_out_ready, busy, misaligned, cache_enable;
  logic [31:0] cache_address, cache_data_in, cache_data_out;
  logic [3:0]  cache_write_enable;
  logic        cache_data_out_ready, cache_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ramio dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .enable               (enable),
    .address              (address),
    .write_type           (write_type),
    .read_type            (read_type),
    .data_in              (data_in),
    .data_out             (data_out),
    .data_out_ready       (data_out_ready),
    .busy                 (busy),
    .misaligned           (misaligned),
    .cache_enable         (cache_enable),
    .cache_address        (cache_address),
    .cache_write_enable   (cache_write_enable),
    .cache_data_in        (cache_data_in),
    .cache_data_out       (cache_data_out),
    .cache_data_out_ready (cache_data_out_ready),
    .cache_busy           (cache_busy)
  );

  // Cache model: 16 words indexed by address[5:2], zero read latency,
  // optional miss on one address for a programmed number of cycles.
  logic [31:0] mem [0:15];
  logic [31:0] miss_addr = 32'hFFFF_FFFF;
  int          miss_left = 0;

  assign cache_busy           = cache_enable && (cache_address == miss_addr) && (miss_left != 0);
  assign cache_data_out       = mem[cache_address[5:2]];
  assign cache_data_out_ready = cache_enable && !cache_busy;

  always @(posedge clk) begin
    if (cache_busy) miss_left <= miss_left - 1;
    if (cache_enable && !cache_busy)
      for (int b = 0; b < 4; b++)
        if (cache_write_enable[b]) mem[cache_address[5:2]][8*b +: 8] <= cache_data_in[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [31:0] addr, input logic [1:0] wt,
                       input logic [2:0] rt, input logic [31:0] din);
    enable     = en;
    address    = addr;
    write_type = wt;
    read_type  = rt;
    data_in    = din;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifdef RAMIO_SPLIT_ACCESS_EN
  logic [31:0] log_addr [0:3];
  logic [3:0]  log_mask [0:3];
  logic [31:0] log_data [0:3];
  int          log_n;
  int          saw_zero;
  int          mis_seen;

  // Follows a split access from its Idle cycle to Done; returns busy-cycle count
  // and the number of busy cycles that also showed data_out_ready.
  task automatic run_split(output int cycles, output int dor_seen);
    cycles   = 0;
    dor_seen = 0;
    log_n    = 0;
    saw_zero = 0;
    mis_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
      if (data_out_ready) dor_seen++;
      if (misaligned) mis_seen++;
      if (cache_enable && cache_address == 32'd0) saw_zero = 1;
      if (cache_write_enable != 4'b0000 && log_n < 4) begin
        log_addr[log_n] = cache_address;
        log_mask[log_n] = cache_write_enable;
        log_data[log_n] = cache_data_in;
        log_n++;
      end
    end
  endtask

  task automatic finish_split();
    next_cycle();
    drive(1'b0, 32'd0, 2'b00, 3'b000, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, data_out_ready}, 32'd0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;

    // Reset holds every output at zero even with a live request.
    drive(1'b1, 32'h100, 2'b00, 3'b011, 32'd0);
    @(negedge clk);
    check("rst_cache_enable", {31'd0, cache_enable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    drive(1'b0, 32'd0, 2'b00, 3'b000, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Aligned word store, single cycle.
    drive(1'b1, 32'h100, 2'b11, 3'b000, 32'h1234_5678);
    @(negedge clk);
    check("st_cache_enable", {31'd0, cache_enable}, 32'd1);
    check("st_address", cache_address, 32'h100);
    check("st_mask", {28'd0, cache_write_enable}, 32'hF);
    check("st_data", cache_data_in, 32'h1234_5678);
    check("st_busy", {31'd0, busy}, 32'd0);
    next_cycle();
    drive(1'b1, 32'h100, 2'b00, 3'b011, 32'd0);
    @(negedge clk);
    check("ld_word", data_out, 32'h1234_5678);
    check("ld_ready", {31'd0, data_out_ready}, 32'd1);
    check("ld_busy", {31'd0, busy}, 32'd0);
    next_cycle();

    // Sub-word loads with sign/zero extension.
    mem[0] = 32'h80FF_7F01;
    drive(1'b1, 32'h103, 2'b00, 3'b101, 32'd0);
    @(negedge clk);
    check("ld_sbyte_103", data_out, 32'hFFFF_FF80);
    next_cycle();
    drive(1'b1, 32'h102, 2'b00, 3'b001, 32'd0);
    @(negedge clk);
    check("ld_ubyte_102", data_out, 32'h0000_00FF);
    next_cycle();
    drive(1'b1, 32'h101, 2'b00, 3'b110, 32'd0);
    @(negedge clk);
    check("ld_shalf_101", data_out, 32'hFFFF_FF7F);
    next_cycle();

    // Write takes precedence over read.
    drive(1'b1, 32'h108, 2'b11, 3'b011, 32'h55);
    @(negedge clk);
    check("prec_ready", {31'd0, data_out_ready}, 32'd0);
    check("prec_mask", {28'd0, cache_write_enable}, 32'hF);
    next_cycle();

    // No request.
    drive(1'b0, 32'h100, 2'b11, 3'b000, 32'h1);
    @(negedge clk);
    check("idle_cache_enable", {31'd0, cache_enable}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    next_cycle();

`ifdef RAMIO_SPLIT_ACCESS_EN
    begin
      int cyc, dor;
      mem[0] = 32'd0;
      mem[1] = 32'd0;

      // Straddling word store at 0x102.
      drive(1'b1, 32'h102, 2'b11, 3'b000, 32'hAABB_CCDD);
      run_split(cyc, dor);
      check("sst_cycles", cyc, 5);
      check("sst_mis", mis_seen, 0);
      check("sst_writes", log_n, 2);
      check("sst_lo_addr", log_addr[0], 32'h100);
      check("sst_lo_mask", {28'd0, log_mask[0]}, 32'hC);
      check("sst_lo_data", log_data[0], 32'hCCDD_0000);
      check("sst_hi_addr", log_addr[1], 32'h104);
      check("sst_hi_mask", {28'd0, log_mask[1]}, 32'h3);
      check("sst_hi_data", log_data[1], 32'h0000_AABB);
      check("sst_done_ready", {31'd0, data_out_ready}, 32'd0);
      finish_split();

      // Straddling word load back.
      drive(1'b1, 32'h102, 2'b00, 3'b011, 32'd0);
      run_split(cyc, dor);
      check("sld_cycles", cyc, 5);
      check("sld_early_ready", dor, 0);
      check("sld_ready", {31'd0, data_out_ready}, 32'd1);
      check("sld_data", data_out, 32'hAABB_CCDD);
      finish_split();

      // Split store with a 30-cycle miss on the hi word.
      miss_addr = 32'h104;
      miss_left = 30;
      drive(1'b1, 32'h101, 2'b11, 3'b000, 32'h1122_3344);
      run_split(cyc, dor);
      check("miss_cycles", cyc, 34);
      check("miss_writes", log_n, 2);
      check("miss_lo_once", (log_addr[0] == 32'h100 && log_addr[1] == 32'h104) ? 32'd1 : 32'd0, 32'd1);
      check("miss_drained", miss_left, 0);
      finish_split();
      drive(1'b1, 32'h101, 2'b00, 3'b011, 32'd0);
      run_split(cyc, dor);
      check("miss_ld_data", data_out, 32'h1122_3344);
      finish_split();

      // Wrap-around from 0xFFFFFFFC to 0x00000000.
      mem[15] = 32'hAB00_0000;
      mem[0]  = 32'h0000_00CD;
      drive(1'b1, 32'hFFFF_FFFF, 2'b00, 3'b010, 32'd0);
      run_split(cyc, dor);
      check("wrap_hi_zero", saw_zero, 1);
      check("wrap_data", data_out, 32'h0000_CDAB);
      finish_split();

      // Reset in the middle of the hi phase.
      drive(1'b1, 32'hFFFF_FFFF, 2'b00, 3'b010, 32'd0);
      saw_zero = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (cache_enable && cache_address == 32'd0) begin
          saw_zero = 1;
          break;
        end
      end
      check("rstmid_reached_hi", saw_zero, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_cache_enable", {31'd0, cache_enable}, 32'd0);
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_address", cache_address, 32'd0);
      next_cycle();
      rst_n = 1'b1;
      drive(1'b1, 32'h100, 2'b00, 3'b011, 32'd0);
      @(negedge clk);
      check("rstmid_idle_pass", {31'd0, cache_enable}, 32'd1);
      check("rstmid_idle_busy", {31'd0, busy}, 32'd0);
      check("rstmid_idle_data", data_out, 32'h0000_00CD);
      next_cycle();
    end
`else
    // Straddling access without split support is flagged and not performed.
    drive(1'b1, 32'h101, 2'b00, 3'b011, 32'd0);
    @(negedge clk);
    check("mis_flag", {31'd0, misaligned}, 32'd1);
    check("mis_cache_enable", {31'd0, cache_enable}, 32'd0);
    check("mis_busy", {31'd0, busy}, 32'd0);
    check("mis_ready", {31'd0, data_out_ready}, 32'd0);
    next_cycle();
    drive(1'b1, 32'h103, 2'b10, 3'b000, 32'h1);
    @(negedge clk);
    check("mis_half_store", {31'd0, misaligned}, 32'd1);
    check("mis_half_mask", {28'd0, cache_write_enable}, 32'd0);
    next_cycle();
    drive(1'b0, 32'd0, 2'b00, 3'b000, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
